// File: rtl/spi_lane_rxtx.sv
// spi_lane_rxtx: SPI target with 1/2/4 data lanes, configurable word width and SPI mode.
// Moves whole N_BITS words between the SPI pins and the core logic through valid/ack handshakes.
//
// Optional feature: define SPI_LANE_RXTX_UNDERRUN_EN to add the sticky tx_underrun output.
//
// Ports:
//   clk, rst          core clock, asynchronous active-high reset
//   sck, cs_n, sdi    SPI pins (asynchronous to clk); only sdi[LANES-1:0] is used
//   sdo, sdo_oe       data-out pins and per-lane output enables
//   din, din_valid    received word and its one-cycle strobe
//   dout, dout_valid  word to transmit and its valid flag
//   dout_ack          one-cycle strobe when dout has been loaded into the shifter
//   word_abort        one-cycle strobe when cs_n rose part-way through a word
//   tx_underrun       (optional) sticky flag: a word slot had no dout to send
module spi_lane_rxtx #(
    parameter int unsigned N_BITS = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned CPOL   = 0,
    parameter int unsigned CPHA   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              cs_n,
    input  logic [3:0]        sdi,
    output logic [3:0]        sdo,
    output logic [3:0]        sdo_oe,
    output logic [N_BITS-1:0] din,
    output logic              din_valid,
    input  logic [N_BITS-1:0] dout,
    input  logic              dout_valid,
    output logic              dout_ack,
    output logic              word_abort
`ifdef SPI_LANE_RXTX_UNDERRUN_EN
    ,
    output logic              tx_underrun
`endif
);

    localparam int unsigned BEATS     = N_BITS / LANES;
    localparam int unsigned CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic        IDLE_LVL  = CPOL[0];
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [3:0]  OE_MASK   = 4'((1 << LANES) - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("spi_lane_rxtx: LANES must be 1, 2 or 4");
    end
    if (N_BITS == 0 || (N_BITS % LANES) != 0) begin : g_bad_width
        $error("spi_lane_rxtx: N_BITS must be a non-zero multiple of LANES");
    end

    typedef enum logic {StIdle, StActive} state_e;

    state_e            state;
    logic              sck_s1, sck_s2, sck_s3;
    logic              cs_s1, cs_s2, cs_s3;
    logic [LANES-1:0]  sdi_s1, sdi_s2;
    logic [CW-1:0]     beat_cnt;
    logic [N_BITS-1:0] rx_sr, tx_sr, rx_next;
    logic              lead_edge, trail_edge, sample_edge, shift_edge;
    logic              cs_fall, cs_rise, frame_start, frame_end, tx_load;
    logic              unused_sdi;

    // Upper sdi pins are unused when LANES < 4.
    assign unused_sdi = ^sdi;

    // Edges are seen one clk after the second synchroniser stage.
    assign lead_edge   = (sck_s2 != IDLE_LVL) && (sck_s3 == IDLE_LVL);
    assign trail_edge  = (sck_s2 == IDLE_LVL) && (sck_s3 != IDLE_LVL);
    assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
    assign cs_fall     = cs_s3 & ~cs_s2;
    assign cs_rise     = ~cs_s3 & cs_s2;

    assign frame_start = (state == StIdle) && cs_fall;
    assign frame_end   = (state == StActive) && cs_rise;
    assign rx_next     = (rx_sr << LANES) | N_BITS'(sdi_s2);

    // A shift edge with the counter at zero is always a word boundary: in mode CPHA=0 it is the
    // trailing edge right after a wrap, in CPHA=1 the leading edge of a new word.
    assign tx_load = (frame_start && (CPHA == 0)) ||
                     ((state == StActive) && !cs_rise && shift_edge && (beat_cnt == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            sck_s1     <= IDLE_LVL;
            sck_s2     <= IDLE_LVL;
            sck_s3     <= IDLE_LVL;
            cs_s1      <= 1'b1;
            cs_s2      <= 1'b1;
            cs_s3      <= 1'b1;
            sdi_s1     <= '0;
            sdi_s2     <= '0;
            beat_cnt   <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            din        <= '0;
            din_valid  <= 1'b0;
            dout_ack   <= 1'b0;
            word_abort <= 1'b0;
`ifdef SPI_LANE_RXTX_UNDERRUN_EN
            tx_underrun <= 1'b0;
`endif
        end else begin
            sck_s1 <= sck;
            sck_s2 <= sck_s1;
            sck_s3 <= sck_s2;
            cs_s1  <= cs_n;
            cs_s2  <= cs_s1;
            cs_s3  <= cs_s2;
            sdi_s1 <= sdi[LANES-1:0];
            sdi_s2 <= sdi_s1;

            din_valid  <= 1'b0;
            dout_ack   <= 1'b0;
            word_abort <= 1'b0;

            if (frame_start) begin
                state <= StActive;
            end

            if (frame_end) begin
                // cs_n wins over any sck edge detected in the same clk.
                state      <= StIdle;
                beat_cnt   <= '0;
                rx_sr      <= '0;
                tx_sr      <= '0;
                word_abort <= (beat_cnt != '0);
            end else if (state == StActive) begin
                if (sample_edge) begin
                    rx_sr <= rx_next;
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt  <= '0;
                        din       <= rx_next;
                        din_valid <= 1'b1;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                if (shift_edge && (beat_cnt != '0)) begin
                    tx_sr <= tx_sr << LANES;
                end
            end

            if (tx_load) begin
                tx_sr    <= dout_valid ? dout : '0;
                dout_ack <= dout_valid;
            end

`ifdef SPI_LANE_RXTX_UNDERRUN_EN
            // Cleared by the frame-starting cs_n fall, which may itself underrun.
            if (frame_start) begin
                tx_underrun <= tx_load & ~dout_valid;
            end else if (tx_load && !dout_valid) begin
                tx_underrun <= 1'b1;
            end
`endif
        end
    end

    always_comb begin
        sdo    = '0;
        sdo_oe = '0;
        if (state == StActive) begin
            sdo_oe            = OE_MASK;
            sdo[LANES-1:0]    = tx_sr[N_BITS-1 -: LANES];
        end
    end

endmodule
